bypass_scoreboard: RTL and testbench

BYPASS_SCOREBOARD -- requirements
Module: bypass_scoreboard

---
 rtl/rvga_types.sv | 27 ++
 rtl/bypass_select.sv | 42 ++++
 rtl/bypass_scoreboard.sv | 112 +++++++++++
 tb/tb_bypass_scoreboard.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvga_types.sv
// Shared register-file types and hazard FSM encoding for the rvga pipeline.
// Pure type/constant package; no timing or flow-control behaviour of its own.
package rvga_types;

    localparam int XLEN     = 32;
    localparam int NUM_REGS = 32;
    localparam int REG_W    = 5;

    typedef logic [REG_W-1:0] rvga_reg;
    typedef logic [XLEN-1:0]  rvga_word;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } rvga_hazard_state_e;

    // One-hot mask for a register index; x0 is hardwired and never tracked.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input rvga_reg r);
        logic [NUM_REGS-1:0] v;
        v = '0;
        if (r != '0) begin
            v[r] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/bypass_select.sv
// Per-operand forwarding select: youngest matching stage wins, zero latency.
// Flags a hazard on load-use or an outstanding long-latency write; no internal state.
module bypass_select
    import rvga_types::*;
#(
    parameter int NUM_STAGES = 3
) (
    input  logic [NUM_STAGES-1:0] i_rd_w_v,
    input  rvga_reg [NUM_STAGES-1:0] i_rd,
    input  logic [NUM_STAGES-1:0] i_data_v,
    input  rvga_word [NUM_STAGES-1:0] i_data,
    input  rvga_reg               i_rs,
    input  logic                  i_sb_busy,
    output logic                  o_fwd_v,
    output rvga_word              o_fwd_data,
    output logic                  o_hazard
);

    logic     w_hit;
    logic     w_sel_data_v;
    rvga_word w_sel_data;

    // Walk oldest to youngest so the lowest-index match overwrites the rest.
    always_comb begin
        w_hit        = 1'b0;
        w_sel_data_v = 1'b0;
        w_sel_data   = '0;
        for (int s = NUM_STAGES - 1; s >= 0; s--) begin
            if (i_rd_w_v[s] && (i_rd[s] == i_rs) && (i_rs != '0)) begin
                w_hit        = 1'b1;
                w_sel_data_v = i_data_v[s];
                w_sel_data   = i_data[s];
            end
        end
    end

    assign o_fwd_v    = w_hit & w_sel_data_v;
    assign o_fwd_data = o_fwd_v ? w_sel_data : '0;
    // A pipeline match shadows the scoreboard: the in-flight write is newer.
    assign o_hazard   = (w_hit & ~w_sel_data_v) | (~w_hit & i_sb_busy);

endmodule

// File: rtl/bypass_scoreboard.sv
// Operand bypass network plus long-latency scoreboard; forwarding and stall are combinational.
// Stalls register fetch on load-use or outstanding writes; counts stall cycles, saturating.
module bypass_scoreboard
    import rvga_types::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int NUM_SRC    = 2,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_STAGES-1:0]   stage_rd_w_v,
    input  rvga_reg [NUM_STAGES-1:0]  stage_rd,
    input  logic [NUM_STAGES-1:0]   stage_data_v,
    input  rvga_word [NUM_STAGES-1:0] stage_data,
    input  logic                    rfetch_v,
    input  rvga_reg [NUM_SRC-1:0]   rfetch_rs,
    input  logic                    issue_v,
    input  rvga_reg                 issue_rd,
    input  logic                    complete_v,
    input  rvga_reg                 complete_rd,
    input  logic                    flush,
    output logic [NUM_SRC-1:0]      fwd_v,
    output rvga_word [NUM_SRC-1:0]  fwd_data,
    output logic                    stall,
    output logic [CNT_W-1:0]        stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [NUM_REGS-1:0] r_sb;
    logic [NUM_REGS-1:0] w_sb_next;
    logic [NUM_SRC-1:0]  w_hazard;
    logic [CNT_W-1:0]    r_stall_cnt;
    rvga_hazard_state_e  r_state;
    rvga_hazard_state_e  w_state_next;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        bypass_select #(
            .NUM_STAGES (NUM_STAGES)
        ) u_select (
            .i_rd_w_v   (stage_rd_w_v),
            .i_rd       (stage_rd),
            .i_data_v   (stage_data_v),
            .i_data     (stage_data),
            .i_rs       (rfetch_rs[g]),
            .i_sb_busy  (r_sb[rfetch_rs[g]]),
            .o_fwd_v    (fwd_v[g]),
            .o_fwd_data (fwd_data[g]),
            .o_hazard   (w_hazard[g])
        );
    end

    assign stall     = rfetch_v & (|w_hazard);
    assign stall_cnt = r_stall_cnt;

    // Issue is applied after complete so a same-cycle pair leaves the bit set.
    always_comb begin
        w_sb_next = r_sb;
        if (complete_v) begin
            w_sb_next = w_sb_next & ~reg_onehot(complete_rd);
        end
        if (issue_v) begin
            w_sb_next = w_sb_next | reg_onehot(issue_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sb <= '0;
        end else if (flush) begin
            r_sb <= '0;
        end else begin
            r_sb <= w_sb_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (stall && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (stall) begin
                    w_state_next = STALL;
                end
            end
            STALL: begin
                if (!stall || flush) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bypass_scoreboard.sv
// Self-checking bench: directed vector table, corner sequences and a random run vs a reference model.
module tb_bypass_scoreboard;
    import rvga_types::*;

    localparam int NS   = 3;
    localparam int NSRC = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic [NS-1:0]        stage_rd_w_v;
    rvga_reg [NS-1:0]     stage_rd;
    logic [NS-1:0]        stage_data_v;
    rvga_word [NS-1:0]    stage_data;
    logic                 rfetch_v;
    rvga_reg [NSRC-1:0]   rfetch_rs;
    logic                 issue_v;
    rvga_reg              issue_rd;
    logic                 complete_v;
    rvga_reg              complete_rd;
    logic                 flush;

    logic [NSRC-1:0]      fwd_v, fwd_v4;
    rvga_word [NSRC-1:0]  fwd_data, fwd_data4;
    logic                 stall, stall4;
    logic [15:0]          stall_cnt;
    logic [3:0]           stall_cnt4;

    bypass_scoreboard #(.NUM_STAGES(NS), .NUM_SRC(NSRC), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .stage_rd_w_v(stage_rd_w_v), .stage_rd(stage_rd),
        .stage_data_v(stage_data_v), .stage_data(stage_data), .rfetch_v(rfetch_v),
        .rfetch_rs(rfetch_rs), .issue_v(issue_v), .issue_rd(issue_rd),
        .complete_v(complete_v), .complete_rd(complete_rd), .flush(flush),
        .fwd_v(fwd_v), .fwd_data(fwd_data), .stall(stall), .stall_cnt(stall_cnt)
    );

    bypass_scoreboard #(.NUM_STAGES(NS), .NUM_SRC(NSRC), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .stage_rd_w_v(stage_rd_w_v), .stage_rd(stage_rd),
        .stage_data_v(stage_data_v), .stage_data(stage_data), .rfetch_v(rfetch_v),
        .rfetch_rs(rfetch_rs), .issue_v(issue_v), .issue_rd(issue_rd),
        .complete_v(complete_v), .complete_rd(complete_rd), .flush(flush),
        .fwd_v(fwd_v4), .fwd_data(fwd_data4), .stall(stall4), .stall_cnt(stall_cnt4)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state: outstanding set, counters, and whether the FSM is stalling.
    bit [31:0] m_sb;
    int        m_cnt16, m_cnt4;
    bit        m_in_stall;
    bit        m_fv [NSRC];
    rvga_word  m_fd [NSRC];
    bit        m_stall;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic model_eval();
        bit haz;
        int sel;
        haz = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            sel = -1;
            m_fv[i] = 1'b0;
            m_fd[i] = '0;
            if (rfetch_rs[i] != 0) begin
                for (int s = 0; s < NS; s++) begin
                    if (stage_rd_w_v[s] && stage_rd[s] == rfetch_rs[i]) begin
                        sel = s;
                        break;
                    end
                end
            end
            if (sel >= 0) begin
                if (stage_data_v[sel]) begin
                    m_fv[i] = 1'b1;
                    m_fd[i] = stage_data[sel];
                end else begin
                    haz = 1'b1;
                end
            end else if (m_sb[rfetch_rs[i]]) begin
                haz = 1'b1;
            end
        end
        m_stall = rfetch_v && haz;
    endtask

    task automatic model_update();
        if (!rst_n) begin
            m_sb = '0; m_cnt16 = 0; m_cnt4 = 0; m_in_stall = 1'b0;
        end else begin
            if (m_stall) begin
                if (m_cnt16 < 65535) m_cnt16++;
                if (m_cnt4 < 15) m_cnt4++;
            end
            m_in_stall = m_in_stall ? (m_stall && !flush) : m_stall;
            if (flush) m_sb = '0;
            else begin
                if (complete_v && complete_rd != 0) m_sb[complete_rd] = 1'b0;
                if (issue_v && issue_rd != 0) m_sb[issue_rd] = 1'b1;
            end
        end
    endtask

    // Inputs are driven just after negedge; compare mid-cycle, then advance.
    task automatic tick();
        #2;
        model_eval();
        for (int i = 0; i < NSRC; i++) begin
            chk($sformatf("fwd_v[%0d]", i), fwd_v[i], m_fv[i]);
            chk($sformatf("fwd_data[%0d]", i), fwd_data[i], m_fd[i]);
            chk($sformatf("w4 fwd_v[%0d]", i), fwd_v4[i], m_fv[i]);
        end
        chk("stall", stall, m_stall);
        chk("w4 stall", stall4, m_stall);
        chk("stall_cnt", stall_cnt, m_cnt16);
        chk("w4 stall_cnt", stall_cnt4, m_cnt4);
        chk("fsm", dut.r_state == STALL, m_in_stall);
        chk("w4 fsm", dut4.r_state == STALL, m_in_stall);
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst_n = 1'b1; stage_rd_w_v = '0; stage_rd = '0; stage_data_v = '0; stage_data = '0;
        rfetch_v = 1'b0; rfetch_rs = '0; issue_v = 1'b0; issue_rd = '0;
        complete_v = 1'b0; complete_rd = '0; flush = 1'b0;
    endtask

    typedef struct {
        logic [2:0]   wv, dv;
        rvga_reg [2:0]  rd;
        rvga_word [2:0] d;
        logic         rv;
        rvga_reg [1:0]  rs;
        logic [1:0]   e_fv;
        rvga_word     e_d0, e_d1;
        logic         e_st;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] wv, input logic [2:0] dv,
                                input rvga_reg r0, input rvga_reg r1, input rvga_reg r2,
                                input rvga_word d0, input rvga_word d1, input rvga_word d2,
                                input logic rv, input rvga_reg s0, input rvga_reg s1,
                                input logic [1:0] e_fv, input rvga_word e_d0,
                                input rvga_word e_d1, input logic e_st);
        vec_t v;
        v.wv = wv; v.dv = dv; v.rd = {r2, r1, r0}; v.d = {d2, d1, d0};
        v.rv = rv; v.rs = {s1, s0}; v.e_fv = e_fv; v.e_d0 = e_d0; v.e_d1 = e_d1; v.e_st = e_st;
        return v;
    endfunction

    vec_t tbl [8];

    initial begin
        tbl[0] = mk(3'b011, 3'b111, 5, 5, 0, 32'hAAAA, 32'hBBBB, 0, 1, 5, 0, 2'b01, 32'hAAAA, 0, 0);
        tbl[1] = mk(3'b011, 3'b110, 7, 7, 0, 32'h1, 32'h2, 0, 1, 0, 7, 2'b00, 0, 0, 1);
        tbl[2] = mk(3'b001, 3'b001, 0, 0, 0, 32'h1234, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0);
        tbl[3] = mk(3'b100, 3'b100, 0, 0, 12, 0, 0, 32'hCAFE, 1, 12, 12, 2'b11, 32'hCAFE, 32'hCAFE, 0);
        tbl[4] = mk(3'b000, 3'b111, 3, 4, 5, 1, 2, 3, 1, 3, 4, 2'b00, 0, 0, 0);
        tbl[5] = mk(3'b011, 3'b110, 7, 7, 0, 32'h1, 32'h2, 0, 0, 0, 7, 2'b00, 0, 0, 0);
        tbl[6] = mk(3'b011, 3'b010, 8, 9, 0, 32'h7, 32'h5555, 0, 1, 9, 8, 2'b01, 32'h5555, 0, 1);
        tbl[7] = mk(3'b111, 3'b101, 1, 2, 2, 32'h11, 32'h22, 32'h33, 1, 2, 1, 2'b10, 0, 32'h11, 1);

        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_sb = '0; m_cnt16 = 0; m_cnt4 = 0; m_in_stall = 1'b0;
        #1;
        chk("reset stall_cnt", stall_cnt, 0);
        chk("reset fsm idle", dut.r_state == STALL, 0);
        chk("reset stall", stall, 0);
        tick();

        for (int k = 0; k < 8; k++) begin
            idle_inputs();
            stage_rd_w_v = tbl[k].wv; stage_data_v = tbl[k].dv;
            stage_rd = tbl[k].rd; stage_data = tbl[k].d;
            rfetch_v = tbl[k].rv; rfetch_rs = tbl[k].rs;
            #1;
            chk($sformatf("vec%0d fwd_v", k), fwd_v, tbl[k].e_fv);
            chk($sformatf("vec%0d fwd_data0", k), fwd_data[0], tbl[k].e_d0);
            chk($sformatf("vec%0d fwd_data1", k), fwd_data[1], tbl[k].e_d1);
            chk($sformatf("vec%0d stall", k), stall, tbl[k].e_st);
            tick();
        end

        // Long-latency write to x3 blocks its reader until retirement.
        idle_inputs(); issue_v = 1'b1; issue_rd = 3; tick();
        idle_inputs(); rfetch_v = 1'b1; rfetch_rs = {5'd0, 5'd3};
        for (int c = 0; c < 3; c++) begin
            #1 chk("sb x3 stall", stall, 1);
            tick();
        end
        complete_v = 1'b1; complete_rd = 3;
        #1 chk("sb x3 stall in complete cycle", stall, 1);
        tick();
        complete_v = 1'b0;
        #1 chk("sb x3 released", stall, 0);
        tick();

        // x0 is never tracked.
        idle_inputs(); issue_v = 1'b1; issue_rd = 0; tick();
        idle_inputs();
        #1 chk("x0 issue ignored", dut.r_sb, 0);
        tick();

        // Issue wins over complete, then flush wipes it.
        idle_inputs(); issue_v = 1'b1; complete_v = 1'b1; issue_rd = 9; complete_rd = 9; tick();
        idle_inputs(); rfetch_v = 1'b1; rfetch_rs = {5'd0, 5'd9};
        #1 chk("x9 bit set", dut.r_sb[9], 1);
        chk("x9 stall", stall, 1);
        tick();
        #1 chk("x9 fsm stall", dut.r_state == STALL, 1);
        flush = 1'b1;
        #0 chk("x9 stall in flush cycle", stall, 1);
        tick();
        flush = 1'b0;
        #1 chk("x9 bit cleared", dut.r_sb[9], 0);
        chk("x9 stall after flush", stall, 0);
        chk("x9 fsm idle after flush", dut.r_state == STALL, 0);
        tick();

        // Saturate the narrow counter, then reset mid-stall.
        idle_inputs(); issue_v = 1'b1; issue_rd = 4; tick();
        idle_inputs(); rfetch_v = 1'b1; rfetch_rs = {5'd0, 5'd4};
        repeat (20) tick();
        #1 chk("w4 stall_cnt saturated", stall_cnt4, 15);
        chk("w4 still stalling", stall4, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1 chk("w4 stall_cnt after reset", stall_cnt4, 0);
        chk("stall_cnt after reset", stall_cnt, 0);
        chk("w4 fsm idle after reset", dut4.r_state == STALL, 0);
        chk("stall after reset", stall, 0);
        tick();

        for (int c = 0; c < 400; c++) begin
            rst_n        = ($urandom_range(0, 99) != 0);
            stage_rd_w_v = 3'($urandom);
            stage_data_v = 3'($urandom);
            for (int s = 0; s < NS; s++) begin
                stage_rd[s]   = 5'($urandom_range(0, 7));
                stage_data[s] = $urandom;
            end
            rfetch_v     = ($urandom_range(0, 4) != 0);
            rfetch_rs[0] = 5'($urandom_range(0, 7));
            rfetch_rs[1] = 5'($urandom_range(0, 7));
            issue_v      = ($urandom_range(0, 4) == 0);
            issue_rd     = 5'($urandom_range(0, 7));
            complete_v   = ($urandom_range(0, 4) == 0);
            complete_rd  = 5'($urandom_range(0, 7));
            flush        = ($urandom_range(0, 29) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
